clk_div_multi: RTL and testbench

- Multi-channel programmable integer clock divider. Successor to the single-channel divider.
- NUM_CH independent channels run from one reference clock. Each channel has its own ratio and enable.
- New relative to the single-channel block:
  - ratio changes are applied glitch-free at period boundaries;
  - a common phase-align input restarts all channels;
  - each channel has a per-period tick output.
- Feeds peripheral clock/strobe generation (UART baud, sampling strobes) in the same system.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 106 ++++++++++
 rtl/clk_div_multi.sv | 39 +++
 tb/tb_clk_div_multi.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   MODE_BYPASS / MODE_DIVIDE : per-channel operating mode encoding
//   MIN_DIV_RATIO             : smallest ratio that actually divides
//   half_ratio()              : length of the high phase for ratio N
package clk_div_pkg;

    localparam logic MODE_BYPASS = 1'b0;
    localparam logic MODE_DIVIDE = 1'b1;

    localparam int unsigned MIN_DIV_RATIO = 2;

    // High phase is floor(N/2); odd ratios get the shorter high phase.
    function automatic logic [31:0] half_ratio(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow ratio, mode and output mux.
// Ports:
//   ref_clk_i    reference clock (rising edge)
//   rst_i        synchronous reset, active-high
//   clk_en_i     channel enable
//   div_ratio_i  requested ratio N (sampled at period end or in bypass)
//   sync_i       phase-align: restart the period if dividing
//   div_clk_o    divided clock (reference clock passed through in bypass)
//   tick_o       high on the last reference cycle of each divided period
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             ref_clk_i,
    input  logic             rst_i,
    input  logic             clk_en_i,
    input  logic [WIDTH-1:0] div_ratio_i,
    input  logic             sync_i,
    output logic             div_clk_o,
    output logic             tick_o
);

    localparam logic [WIDTH-1:0] MinRatio = WIDTH'(MIN_DIV_RATIO);

    logic             mode_q, mode_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;

    logic             period_end;
    logic [WIDTH-1:0] n_next;
    logic [WIDTH-1:0] cnt_next;

    always_comb begin
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        ratio_d    = ratio_q;
        div_d      = div_q;
        tick_d     = 1'b0;
        period_end = (cnt_q == ratio_q - WIDTH'(1));
        n_next     = ratio_q;
        cnt_next   = cnt_q + WIDTH'(1);

        if (mode_q == MODE_BYPASS) begin
            ratio_d = div_ratio_i;
            cnt_d   = '0;
            div_d   = 1'b0;
            // The ratio loaded on the previous edge decides entry, so the
            // divided output first rises one cycle after the load.
            if (clk_en_i && (ratio_q >= MinRatio)) begin
                mode_d  = MODE_DIVIDE;
                ratio_d = ratio_q;
                div_d   = (WIDTH'(0) < WIDTH'(half_ratio(32'(ratio_q))));
            end
        end else if (!clk_en_i) begin
            // Disable is immediate; the running period is abandoned.
            mode_d  = MODE_BYPASS;
            cnt_d   = '0;
            div_d   = 1'b0;
            ratio_d = div_ratio_i;
        end else begin
            if (period_end) begin
                n_next   = div_ratio_i;
                cnt_next = '0;
            end
            // Sync overrides the count but a pending ratio still loads.
            if (sync_i) begin
                cnt_next = '0;
            end
            if (n_next < MinRatio) begin
                mode_d  = MODE_BYPASS;
                cnt_d   = '0;
                div_d   = 1'b0;
                ratio_d = n_next;
            end else begin
                ratio_d = n_next;
                cnt_d   = cnt_next;
                div_d   = (cnt_next < WIDTH'(half_ratio(32'(n_next))));
                tick_d  = (cnt_next == n_next - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_BYPASS;
            cnt_q   <= '0;
            ratio_q <= '0;
            div_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
        end
    end

    // Registered mode select; div_q is stable across the whole cycle.
    assign div_clk_o = (mode_q == MODE_BYPASS) ? ref_clk_i : div_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable integer clock divider.
// Ports:
//   I_ref_clk    reference clock (rising edge)
//   I_rst        synchronous reset, active-high
//   I_clk_en     per-channel enable
//   I_div_ratio  per-channel ratio, channel i at [i*WIDTH +: WIDTH]
//   I_sync       phase-align pulse shared by all channels
//   o_div_clk    per-channel divided clock
//   o_tick       per-channel end-of-period pulse
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 4
) (
    input  logic                    I_ref_clk,
    input  logic                    I_rst,
    input  logic [NUM_CH-1:0]       I_clk_en,
    input  logic [NUM_CH*WIDTH-1:0] I_div_ratio,
    input  logic                    I_sync,
    output logic [NUM_CH-1:0]       o_div_clk,
    output logic [NUM_CH-1:0]       o_tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_div_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .ref_clk_i  (I_ref_clk),
            .rst_i      (I_rst),
            .clk_en_i   (I_clk_en[i]),
            .div_ratio_i(I_div_ratio[i*WIDTH +: WIDTH]),
            .sync_i     (I_sync),
            .div_clk_o  (o_div_clk[i]),
            .tick_o     (o_tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (WIDTH=8, NUM_CH=4).
module tb_clk_div_multi;

    logic        ref_clk;
    logic        rst;
    logic [3:0]  clk_en;
    logic [31:0] div_ratio;
    logic        sync;
    logic [3:0]  div_clk;
    logic [3:0]  tick;

    int n_tests;
    int n_fail;

    logic [3:0]  ed, et;
    int          nn;
    logic [0:17] e3d, e3t;
    logic [0:9]  e4d0, e4t0, e4d1, e4t1;
    logic [0:11] e5d, e5t;
    int          highs, lows, nticks, tick_a, tick_b;

    clk_div_multi #(
        .WIDTH (8),
        .NUM_CH(4)
    ) dut (
        .I_ref_clk  (ref_clk),
        .I_rst      (rst),
        .I_clk_en   (clk_en),
        .I_div_ratio(div_ratio),
        .I_sync     (sync),
        .o_div_clk  (div_clk),
        .o_tick     (tick)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic low_half();
        @(negedge ref_clk);
        #1;
    endtask

    // Reset, release with the given enables; returns right after the edge
    // that enters DIVIDE (load edge, then entry edge).
    task automatic start(input logic [3:0] en_v, input logic [31:0] ratio_v);
        rst       = 1'b1;
        clk_en    = 4'h0;
        sync      = 1'b0;
        div_ratio = ratio_v;
        step();
        step();
        rst    = 1'b0;
        clk_en = en_v;
        step();
        step();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        clk_en    = 4'h0;
        sync      = 1'b0;
        div_ratio = {8'd5, 8'd4, 8'd3, 8'd2};

        // 1: reset state, then ratios 2/3/4/5 free-running
        step();
        step();
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_div_hi", 32'(div_clk), 32'hF);
        low_half();
        check("rst_div_lo", 32'(div_clk), 32'h0);
        rst    = 1'b0;
        clk_en = 4'hF;
        step();
        check("t1_load_hi", 32'(div_clk), 32'hF);
        low_half();
        check("t1_load_lo", 32'(div_clk), 32'h0);
        step();
        for (int k = 0; k < 40; k++) begin
            for (int c = 0; c < 4; c++) begin
                nn    = c + 2;
                ed[c] = (k % nn) < (nn / 2);
                et[c] = (k % nn) == (nn - 1);
            end
            check($sformatf("t1_div k=%0d", k), 32'(div_clk), 32'(ed));
            check($sformatf("t1_tick k=%0d", k), 32'(tick), 32'(et));
            step();
        end

        // 2: ratio 0/1 enabled and ratio 6 disabled all stay in bypass
        start(4'b0011, {8'd6, 8'd6, 8'd1, 8'd0});
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t2_hi k=%0d", k), 32'(div_clk), 32'hF);
            check($sformatf("t2_tick k=%0d", k), 32'(tick), 32'h0);
            low_half();
            check($sformatf("t2_lo k=%0d", k), 32'(div_clk), 32'h0);
            step();
        end

        // 3: N=4 -> 7 requested at cnt=1; change lands at the next period
        e3d = 18'b1100_1110000_1110000;
        e3t = 18'b0001_0000001_0000001;
        start(4'b0001, {8'd0, 8'd0, 8'd0, 8'd4});
        for (int k = 0; k < 18; k++) begin
            if (k == 1) div_ratio = {8'd0, 8'd0, 8'd0, 8'd7};
            check($sformatf("t3_div k=%0d", k), 32'(div_clk[0]), 32'(e3d[k]));
            check($sformatf("t3_tick k=%0d", k), 32'(tick[0]), 32'(e3t[k]));
            low_half();
            check($sformatf("t3_div_lo k=%0d", k), 32'(div_clk[0]), 32'(e3d[k]));
            step();
        end

        // 4: N=3 and N=5 out of phase, one-cycle sync realigns both
        e4d0 = 10'b1001001001;
        e4t0 = 10'b0010010010;
        e4d1 = 10'b1100011000;
        e4t1 = 10'b0000100001;
        start(4'b0011, {8'd0, 8'd0, 8'd5, 8'd3});
        for (int k = 0; k < 7; k++) step();
        check("t4_presync_div", 32'(div_clk[1:0]), 32'h0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int j = 0; j < 10; j++) begin
            check($sformatf("t4_div0 j=%0d", j), 32'(div_clk[0]), 32'(e4d0[j]));
            check($sformatf("t4_tick0 j=%0d", j), 32'(tick[0]), 32'(e4t0[j]));
            check($sformatf("t4_div1 j=%0d", j), 32'(div_clk[1]), 32'(e4d1[j]));
            check($sformatf("t4_tick1 j=%0d", j), 32'(tick[1]), 32'(e4t1[j]));
            step();
        end

        // 5: reset mid-period at N=6, then restart through entry latency
        e5d = 12'b111000111000;
        e5t = 12'b000001000001;
        start(4'hF, {8'd6, 8'd6, 8'd6, 8'd6});
        step();
        step();
        low_half();
        check("t5_mid_div_lo", 32'(div_clk), 32'hF);
        rst = 1'b1;
        step();
        check("t5_rst_tick", 32'(tick), 32'h0);
        low_half();
        check("t5_rst_div_lo", 32'(div_clk), 32'h0);
        rst = 1'b0;
        step();
        low_half();
        check("t5_load_div_lo", 32'(div_clk), 32'h0);
        step();
        for (int k = 0; k < 12; k++) begin
            for (int c = 0; c < 4; c++) begin
                ed[c] = e5d[k];
                et[c] = e5t[k];
            end
            check($sformatf("t5_div k=%0d", k), 32'(div_clk), 32'(ed));
            check($sformatf("t5_tick k=%0d", k), 32'(tick), 32'(et));
            step();
        end

        // 6: N=255 for 600 cycles: 127 high, 128 low, ticks 255 apart
        start(4'b0001, {8'd0, 8'd0, 8'd0, 8'd255});
        highs  = 0;
        lows   = 0;
        nticks = 0;
        tick_a = -1;
        tick_b = -1;
        for (int k = 0; k < 600; k++) begin
            if (k < 255) begin
                if (div_clk[0]) highs++;
                else lows++;
            end
            if (tick[0]) begin
                nticks++;
                if (tick_a < 0) tick_a = k;
                else if (tick_b < 0) tick_b = k;
            end
            if (k == 0 || k == 126 || k == 127 || k == 254 || k == 255 || k == 509) begin
                check($sformatf("t6_div k=%0d", k), 32'(div_clk[0]),
                      32'((k % 255) < 127));
            end
            step();
        end
        check("t6_high", 32'(highs), 32'd127);
        check("t6_low", 32'(lows), 32'd128);
        check("t6_nticks", 32'(nticks), 32'd2);
        check("t6_first_tick", 32'(tick_a), 32'd254);
        check("t6_period", 32'(tick_b - tick_a), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
